mips_irq_arb: RTL and testbench
===============================

# mips_irq_arb

Interrupt arbiter and sequencer for the on-chip device block: it collects the timer and two key interrupt sources, turns them into sticky pending bits, applies per-source enables, and selects the highest-priority pending source. It then presents one registered request plus handler address to the CPU core and runs a request/acknowledge/end-of-interrupt handshake. It sits between the device/timer logic and the core's `irq_req`/`irq_addr` inputs and owns the three handler-vector registers.

## Interface
- `NSRC`, 3: number of sources; bit 0 = timer, bit 1 = key1, bit 2 = key2; lower index = higher priority.
- `SYNC_STAGES`, 2: synchronizer depth for the asynchronous key sources (≥2).
- `AW`, 32: vector/address width.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `src_i`  in  NSRC  raw request levels; bit 0 is synchronous to `clk`; bits 1..NSRC-1 are asynchronous.
- `en_i`  in  NSRC  per-source enable (device command-register bits).
- `clr_i`  in  NSRC  one-cycle software clear of pending bits.
- `vec_we_i`  in  NSRC  one-hot write strobe for vector registers.
- `vec_din_i`  in  AW  vector write data.
- `irq_ack_i`  in  1  core accepted the request (single-cycle pulse).
- `eoi_i`  in  1  end of interrupt from the handler return (single-cycle pulse).
- `irq_req_o`  out  1  registered interrupt request.
- `irq_addr_o`  out  AW  registered handler address, valid while `irq_req_o`=1.
- `irq_id_o`  out  2  index of the granted source.
- `pend_o`  out  NSRC  pending bits, readable through the status path.
- `busy_o`  out  1  high in REQ and SERVICE states.

## Operation
- Sources 1..NSRC-1 pass through a `SYNC_STAGES` flop chain. Source 0 is used directly.
- A rising edge on each synchronized source is detected against a one-flop history and sets `pend[i]`. The edge is detected regardless of `en_i`, so disabled sources still latch pending.
- `clr_i[i]` clears `pend[i]`. If a set and a clear arrive in the same cycle, the set wins.
- Vector register `vec[i]` loads `vec_din_i` when `vec_we_i[i]`=1; writes are allowed in any state.
- FSM states are IDLE, REQ and SERVICE.
  - **IDLE:** if `pend & en_i` ≠ 0, grant the lowest set index `g`. Register `irq_id_o`←g and `irq_addr_o`←`vec[g]`, set `irq_req_o`, and go to REQ.
  - **REQ:** hold `irq_req_o`, `irq_addr_o` and `irq_id_o` stable.
    - On `irq_ack_i`: clear `pend[g]`, drop `irq_req_o`, go to SERVICE.
    - If `en_i[g]` falls before the ack: drop `irq_req_o`, keep `pend[g]`, return to IDLE.
    - If ack and enable-fall occur in the same cycle, the ack wins.
  - **SERVICE:** no new request is raised (no nesting). On `eoi_i`, go to IDLE.
- A higher-priority source becoming pending during REQ does not pre-empt the current grant. It is granted on the next IDLE evaluation.
- A new edge on the source being serviced re-sets its pending bit and is taken after `eoi_i`.
- `irq_ack_i` is ignored outside REQ. `eoi_i` is ignored outside SERVICE.
- Vector writes during REQ do not change `irq_addr_o`; the address is latched at grant.

## Timing
- Reset values:
  - Outputs: `irq_req_o`=0, `irq_addr_o`=0, `irq_id_o`=0, `pend_o`=0, `busy_o`=0.
  - Internal: all `vec`=0, synchronizers and edge history 0, FSM in IDLE.
- Latency:
  - Timer: `src_i[0]` rises at edge N, `pend_o[0]`=1 after edge N+1, `irq_req_o`=1 after edge N+2.
  - Keys: add `SYNC_STAGES` cycles to the timer latency.
- Ack: `irq_ack_i` sampled at edge M gives `irq_req_o`=0 and `pend[g]`=0 after edge M.
- EOI: `eoi_i` at edge M puts the FSM in IDLE after edge M. The earliest next `irq_req_o` is after edge M+1, so there is at least one idle cycle between interrupts.
- Reset mid-operation: asynchronous assertion drops `irq_req_o` and clears pending immediately, with no handshake completion required.

## Structure
- Add to `mips789_defs.v`:
  - source index defines `IRQ_SRC_TMR`=0, `IRQ_SRC_KEY1`=1, `IRQ_SRC_KEY2`=2;
  - FSM state encodings `IRQ_IDLE`/`IRQ_REQ`/`IRQ_SERVICE`.
- One sub-module, `irq_sync_edge`, holds the synchronizer chain plus rising-edge detector. It has a parameter for stages, with 0 meaning bypass for source 0, and is instantiated once per source.
- Priority encoder, pending register, vectors and FSM live in the top.

## Test plan
- **Timer grant:** `vec[0]`=0x0000_0100, `en_i`=3'b001, pulse `src_i[0]` → `irq_req_o`=1 two cycles later, `irq_addr_o`=0x100, `irq_id_o`=0. Ack → req=0, `pend_o`=0.
- **Priority:** all three pending and enabled, vectors 0x100/0x200/0x300 → grants in order 0x100, 0x200, 0x300, each after ack plus eoi, with one idle cycle between.
- **Masking and withdrawal:** key1 edge with `en_i[1]`=0 → `pend_o`=3'b010, no req. Set `en_i[1]`=1 → req with 0x200. Clear `en_i[1]` before ack → req drops, `pend_o` stays 3'b010.
- **Set beats clear:** `clr_i[2]` and a synchronized key2 edge in the same cycle → `pend_o[2]`=1.
- **No nesting:** in SERVICE for key2, pulse timer → no req until `eoi_i`. Then the timer is granted at 0x100 after one idle cycle.
- **Async reset mid-REQ:** assert `rst` while `irq_req_o`=1 → `irq_req_o`=0, `pend_o`=0 and all vectors read 0 without waiting for a clock edge.

Source files
------------

// File: rtl/mips_irq_arb_pkg.sv
// rtl/mips_irq_arb_pkg.sv - shared source indices and FSM state encoding for the interrupt arbiter
package mips_irq_arb_pkg;

    localparam int IRQ_SRC_TMR  = 0;
    localparam int IRQ_SRC_KEY1 = 1;
    localparam int IRQ_SRC_KEY2 = 2;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - optional synchronizer chain plus rising-edge detector for one source
module irq_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic synced;
    logic hist_q;

    // STAGES == 0 is used for the timer, which is already synchronous to clk
    generate
        if (STAGES == 0) begin : g_bypass
            assign synced = d_i;
        end else begin : g_sync
            logic [STAGES-1:0] sync_q;

            // shift the raw level through the metastability chain
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= d_i;
                    for (int k = 1; k < STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign synced = sync_q[STAGES-1];
        end
    endgenerate

    // one-flop history of the synchronized level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= synced;
        end
    end

    assign rise_o = synced & ~hist_q;

endmodule

// File: rtl/mips_irq_arb.sv
// rtl/mips_irq_arb.sv - interrupt pending/enable/priority arbiter with req/ack/eoi sequencer
module mips_irq_arb
    import mips_irq_arb_pkg::*;
#(
    parameter int NSRC        = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AW          = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_i,
    input  logic [NSRC-1:0] en_i,
    input  logic [NSRC-1:0] clr_i,
    input  logic [NSRC-1:0] vec_we_i,
    input  logic [AW-1:0]   vec_din_i,
    input  logic            irq_ack_i,
    input  logic            eoi_i,
    output logic            irq_req_o,
    output logic [AW-1:0]   irq_addr_o,
    output logic [1:0]      irq_id_o,
    output logic [NSRC-1:0] pend_o,
    output logic            busy_o
);

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [AW-1:0]   vec_q [NSRC];
    irq_state_e      state_q, state_d;
    logic [1:0]      id_q, id_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            gnt_valid;
    logic [1:0]      gnt_idx;
    logic [AW-1:0]   gnt_vec;
    logic            ack_take;
    logic [NSRC-1:0] ack_mask;

    generate
        for (genvar i = 0; i < NSRC; i++) begin : g_src
            irq_sync_edge #(
                .STAGES((i == 0) ? 0 : SYNC_STAGES)
            ) u_sync_edge (
                .clk    (clk),
                .rst    (rst),
                .d_i    (src_i[i]),
                .rise_o (rise[i])
            );
        end
    endgenerate

    // lowest enabled pending index wins; its vector is picked here to avoid an out-of-range array index
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        gnt_vec   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend_q[i] && en_i[i]) begin
                gnt_valid = 1'b1;
                gnt_idx   = 2'(i);
                gnt_vec   = vec_q[i];
            end
        end
    end

    // pending: software clear and ack clear, but a same-cycle edge always re-sets the bit
    always_comb begin
        ack_take = (state_q == IRQ_REQ) && irq_ack_i;
        ack_mask = ack_take ? (NSRC'(1) << id_q) : '0;
        pend_d   = (pend_q & ~clr_i & ~ack_mask) | rise;
    end

    // pending register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // handler vector registers, writable in any state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSRC; i++) begin
                vec_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (vec_we_i[i]) begin
                    vec_q[i] <= vec_din_i;
                end
            end
        end
    end

    // FSM state plus the grant id/address latched at grant time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IRQ_IDLE;
            id_q    <= 2'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
        end
    end

    // next-state: grant from IDLE, ack beats enable withdrawal in REQ, eoi leaves SERVICE
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        case (state_q)
            IRQ_IDLE: begin
                if (gnt_valid) begin
                    state_d = IRQ_REQ;
                    id_d    = gnt_idx;
                    addr_d  = gnt_vec;
                end
            end
            IRQ_REQ: begin
                if (irq_ack_i) begin
                    state_d = IRQ_SERVICE;
                end else if (!en_i[id_q]) begin
                    state_d = IRQ_IDLE;
                end
            end
            IRQ_SERVICE: begin
                if (eoi_i) begin
                    state_d = IRQ_IDLE;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    // outputs decoded from registered state only
    always_comb begin
        irq_req_o  = (state_q == IRQ_REQ);
        busy_o     = (state_q != IRQ_IDLE);
        irq_id_o   = id_q;
        irq_addr_o = addr_q;
        pend_o     = pend_q;
    end

endmodule

// File: tb/tb_mips_irq_arb.sv
// tb/tb_mips_irq_arb.sv - self-checking bench for mips_irq_arb
module tb_mips_irq_arb;

    localparam int NSRC = 3;
    localparam int SS   = 2;
    localparam int AW   = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [NSRC-1:0] src, en, clr, we;
    logic [AW-1:0]   din;
    logic            ack, eoi;
    logic            req, busy;
    logic [AW-1:0]   addr;
    logic [1:0]      id;
    logic [NSRC-1:0] pend;

    int errs   = 0;
    int checks = 0;

    mips_irq_arb #(.NSRC(NSRC), .SYNC_STAGES(SS), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_i      (src),
        .en_i       (en),
        .clr_i      (clr),
        .vec_we_i   (we),
        .vec_din_i  (din),
        .irq_ack_i  (ack),
        .eoi_i      (eoi),
        .irq_req_o  (req),
        .irq_addr_o (addr),
        .irq_id_o   (id),
        .pend_o     (pend),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  src, en, clr;
        logic        ack, eoi;
        logic        req;
        logic [1:0]  id;
        logic [31:0] addr;
        logic [2:0]  pend;
        logic        busy;
    } row_t;

    row_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        src = '0; clr = '0; we = '0; din = '0; ack = 1'b0; eoi = 1'b0;
    endtask

    task automatic wvec(input int i, input logic [31:0] v);
        we  = 3'(1 << i);
        din = v;
        cyc();
        we  = '0;
        din = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        en = '0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (!req && n < budget) begin
            cyc();
            n++;
        end
        chk("req_wait", {31'b0, req}, 32'd1);
    endtask

    // behavioural reference: levels delayed through key sync lines, edges set pending,
    // mode 0 = nothing outstanding, 1 = waiting for core ack, 2 = handler running
    bit              m_on = 1'b0;
    bit [2:0]        m_pend;
    bit [SS-1:0]     m_dl [3];
    bit [2:0]        m_hist;
    int              m_mode;
    int              m_g;
    logic [31:0]     m_addr;
    logic [31:0]     m_vec [3];

    always @(posedge clk) begin : model
        bit [2:0] seen, rise, np;
        if (m_on) begin
            seen[0] = src[0];
            for (int i = 1; i < 3; i++) seen[i] = m_dl[i][SS-1];
            rise = seen & ~m_hist;
            np = m_pend & ~clr;
            if (m_mode == 1 && ack) np[m_g] = 1'b0;
            np = np | rise;
            case (m_mode)
                0: if ((m_pend & en) != 0) begin
                    for (int i = 2; i >= 0; i--) if (m_pend[i] && en[i]) m_g = i;
                    m_addr = m_vec[m_g];
                    m_mode = 1;
                end
                1: if (ack) m_mode = 2; else if (!en[m_g]) m_mode = 0;
                default: if (eoi) m_mode = 0;
            endcase
            m_pend = np;
            m_hist = seen;
            for (int i = 1; i < 3; i++) m_dl[i] = {m_dl[i][SS-2:0], src[i]};
            for (int i = 0; i < 3; i++) if (we[i]) m_vec[i] = din;
        end
    end

    initial begin
        // src, en, clr, ack, eoi | req, id, addr, pend, busy
        tbl[0] = '{3'b001, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,   3'b001, 1'b0};
        tbl[1] = '{3'b000, 3'b001, 3'b000, 1'b0, 1'b0, 1'b1, 2'd0, 32'h100, 3'b001, 1'b1};
        tbl[2] = '{3'b000, 3'b001, 3'b000, 1'b0, 1'b0, 1'b1, 2'd0, 32'h100, 3'b001, 1'b1};
        tbl[3] = '{3'b000, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,   3'b000, 1'b1};
        tbl[4] = '{3'b000, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,   3'b000, 1'b1};
        tbl[5] = '{3'b000, 3'b001, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,   3'b000, 1'b0};
        tbl[6] = '{3'b000, 3'b001, 3'b000, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0,   3'b000, 1'b0};

        do_reset();
        chk("rst_req",  {31'b0, req}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_id",   {30'b0, id}, 32'd0);
        chk("rst_pend", {29'b0, pend}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);

        wvec(0, 32'h100);
        wvec(1, 32'h200);
        wvec(2, 32'h300);
        en = 3'b001;

        // timer grant, ack, eoi, and ack/eoi outside their states
        for (int k = 0; k < 7; k++) begin
            src = tbl[k].src; en = tbl[k].en; clr = tbl[k].clr;
            ack = tbl[k].ack; eoi = tbl[k].eoi;
            cyc();
            chk($sformatf("tbl%0d_req", k),  {31'b0, req},  {31'b0, tbl[k].req});
            chk($sformatf("tbl%0d_pend", k), {29'b0, pend}, {29'b0, tbl[k].pend});
            chk($sformatf("tbl%0d_busy", k), {31'b0, busy}, {31'b0, tbl[k].busy});
            if (tbl[k].req) begin
                chk($sformatf("tbl%0d_id", k),   {30'b0, id}, {30'b0, tbl[k].id});
                chk($sformatf("tbl%0d_addr", k), addr, tbl[k].addr);
            end
        end
        idle_in();

        // priority order with one idle cycle between interrupts
        en = 3'b000;
        src = 3'b111; cyc();
        src = 3'b000; cyc(); cyc();
        chk("prio_pend", {29'b0, pend}, 32'h7);
        chk("prio_noreq", {31'b0, req}, 32'd0);
        en = 3'b111; cyc();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("prio%0d_req", k),  {31'b0, req}, 32'd1);
            chk($sformatf("prio%0d_id", k),   {30'b0, id}, 32'(k));
            chk($sformatf("prio%0d_addr", k), addr, 32'(32'h100 * (k + 1)));
            ack = 1'b1; cyc(); ack = 1'b0;
            chk($sformatf("prio%0d_ackreq", k), {31'b0, req}, 32'd0);
            chk($sformatf("prio%0d_busy", k),   {31'b0, busy}, 32'd1);
            eoi = 1'b1; cyc(); eoi = 1'b0;
            chk($sformatf("prio%0d_gap", k), {31'b0, req}, 32'd0);
            if (k < 2) cyc();
        end
        chk("prio_pend_end", {29'b0, pend}, 32'd0);

        // masked key1 latches pending, enable raises req, withdrawal keeps pending
        en = 3'b000;
        src = 3'b010; cyc();
        src = 3'b000; cyc(); cyc();
        chk("mask_pend", {29'b0, pend}, 32'h2);
        chk("mask_noreq", {31'b0, req}, 32'd0);
        en = 3'b010; cyc();
        chk("mask_req", {31'b0, req}, 32'd1);
        chk("mask_addr", addr, 32'h200);
        en = 3'b000; cyc();
        chk("wd_req",  {31'b0, req}, 32'd0);
        chk("wd_pend", {29'b0, pend}, 32'h2);
        chk("wd_busy", {31'b0, busy}, 32'd0);

        // set beats clear on key2
        clr = 3'b010; src = 3'b100; cyc();
        chk("clr_pend", {29'b0, pend}, 32'd0);
        clr = 3'b000; src = 3'b000; cyc();
        clr = 3'b100; cyc();
        chk("setwin_pend", {29'b0, pend}, 32'h4);
        cyc();
        chk("clr2_pend", {29'b0, pend}, 32'd0);
        clr = 3'b000;

        // no nesting: timer during key2 service waits for eoi
        en = 3'b111;
        src = 3'b100; cyc();
        src = 3'b000;
        wait_req(10);
        chk("nest_id",   {30'b0, id}, 32'd2);
        chk("nest_addr", addr, 32'h300);
        ack = 1'b1; cyc(); ack = 1'b0;
        src = 3'b001; cyc(); src = 3'b000;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("nest_hold%0d", k), {31'b0, req}, 32'd0);
        end
        chk("nest_pend", {29'b0, pend}, 32'h1);
        eoi = 1'b1; cyc(); eoi = 1'b0;
        chk("nest_gap", {31'b0, req}, 32'd0);
        cyc();
        chk("nest_req",  {31'b0, req}, 32'd1);
        chk("nest_tid",  {30'b0, id}, 32'd0);
        chk("nest_taddr", addr, 32'h100);

        // asynchronous reset in REQ
        #3;
        rst = 1'b1;
        #1;
        chk("arst_req",  {31'b0, req}, 32'd0);
        chk("arst_pend", {29'b0, pend}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_addr", addr, 32'd0);
        idle_in();
        en = '0;
        cyc();
        rst = 1'b0;
        cyc();
        en = 3'b001; src = 3'b001; cyc();
        src = 3'b000; cyc();
        chk("arst_vec_req",  {31'b0, req}, 32'd1);
        chk("arst_vec_addr", addr, 32'd0);

        // randomized run against the reference model
        do_reset();
        m_pend = '0; m_hist = '0; m_mode = 0; m_g = 0; m_addr = '0;
        for (int i = 0; i < 3; i++) begin
            m_dl[i] = '0;
            m_vec[i] = '0;
        end
        m_on = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            src = 3'($urandom);
            en  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            clr = 3'($urandom) & 3'($urandom) & 3'($urandom);
            ack = ($urandom_range(0, 3) == 0);
            eoi = ($urandom_range(0, 3) == 0);
            we  = ($urandom_range(0, 7) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
            din = $urandom;
            cyc();
            chk($sformatf("rnd%0d_req", n),  {31'b0, req}, {31'b0, m_mode == 1});
            chk($sformatf("rnd%0d_busy", n), {31'b0, busy}, {31'b0, m_mode != 0});
            chk($sformatf("rnd%0d_pend", n), {29'b0, pend}, {29'b0, m_pend});
            if (m_mode == 1) begin
                chk($sformatf("rnd%0d_id", n),   {30'b0, id}, 32'(m_g));
                chk($sformatf("rnd%0d_addr", n), addr, m_addr);
            end
        end
        m_on = 1'b0;
        idle_in();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
